// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the pipelined ALU: operation codes and the
//               status-flag bundle returned with every result.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Codes 0-3 keep the encoding of the legacy 4-bit ALU.
  typedef enum logic [2:0] {
    ALU_OR   = 3'd0,
    ALU_AND  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_ONES = 3'd3,
    ALU_ADD  = 3'd4,
    ALU_SUB  = 3'd5,
    ALU_SHL  = 3'd6,
    ALU_SHR  = 3'd7
  } alu_op_e;

  // Bit order on the wire: {carry, overflow, negative, zero}.
  typedef struct packed {
    logic carry;
    logic overflow;
    logic negative;
    logic zero;
  } alu_flags_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_if
// Description : Request/response bus of the pipelined ALU. Two valid/ready
//               handshakes (request in, result out) plus the delivered-result
//               counter.
//   master : request producer / result consumer side
//   slave  : the ALU pipeline
//   Signals: in_valid, in_ready, operandA, operandB, op      (request)
//            out_valid, out_ready, result, flags, op_count   (response)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  alu_op_e          op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  alu_flags_t       flags;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, operandA, operandB, op, out_ready,
    input  in_ready, out_valid, result, flags, op_count
  );

  modport slave (
    input  in_valid, operandA, operandB, op, out_ready,
    output in_ready, out_valid, result, flags, op_count
  );

endinterface : alu_pipe_if
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU datapath. Computes result and
//               {carry, overflow, negative, zero} for one operand pair.
//   i_a, i_b  : operands (WIDTH)
//   i_op      : operation code
//   o_result  : result (WIDTH)
//   o_flags   : status flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  input  wire alu_op_e          i_op,
  output logic      [WIDTH-1:0] o_result,
  output alu_flags_t            o_flags
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;

  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_ovf;

  // Only the low log2(WIDTH) bits of B select the shift distance.
  assign w_shamt = i_b[SH_W-1:0];

  always_comb begin
    w_result = '0;
    w_sum    = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (i_op)
      ALU_OR:   w_result = i_a | i_b;
      ALU_AND:  w_result = i_a & i_b;
      ALU_XOR:  w_result = i_a ^ i_b;
      ALU_ONES: w_result = '1;
      ALU_ADD: begin
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        w_result = w_sum[MSB:0];
        w_carry  = w_sum[WIDTH];
        // Same-sign operands producing an opposite-sign result.
        w_ovf    = (i_a[MSB] == i_b[MSB]) && (w_result[MSB] != i_a[MSB]);
      end
      ALU_SUB: begin
        // The extra top bit of a zero-extended subtract is the borrow.
        w_sum    = {1'b0, i_a} - {1'b0, i_b};
        w_result = w_sum[MSB:0];
        w_carry  = w_sum[WIDTH];
        w_ovf    = (i_a[MSB] != i_b[MSB]) && (w_result[MSB] != i_a[MSB]);
      end
      ALU_SHL:  w_result = i_a << w_shamt;
      ALU_SHR:  w_result = i_a >> w_shamt;
      default:  w_result = '0;
    endcase
  end

  assign o_result         = w_result;
  assign o_flags.carry    = w_carry;
  assign o_flags.overflow = w_ovf;
  assign o_flags.negative = w_result[MSB];
  assign o_flags.zero     = (w_result == '0);

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined ALU with valid/ready flow control on both
//               request and result sides. S1 holds the accepted request, S2
//               holds the computed result and flags. Full throughput under
//               continuous flow; results held stable under backpressure.
//   clk       : clock, rising edge
//   resetn    : asynchronous active-low reset
//   bus       : alu_pipe_if.slave (request, result, op_count)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  wire logic  clk,
  input  wire logic  resetn,
  alu_pipe_if.slave  bus
);

  // Stage 1: captured request
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  alu_op_e          r_s1_op;

  // Stage 2: computed result
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  alu_flags_t       r_s2_flags;

  logic [CNT_W-1:0] r_op_count;

  logic             w_adv;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_core_result;
  alu_flags_t       w_core_flags;

  // S1 may move into S2 whenever S2 is empty or is being drained this cycle.
  assign w_adv      = !r_s2_valid || bus.out_ready;
  // resetn is folded in so in_ready reads 0 for the whole reset window.
  assign w_in_ready = resetn && (!r_s1_valid || w_adv);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_s2_valid && bus.out_ready;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_op     (r_s1_op),
    .o_result (w_core_result),
    .o_flags  (w_core_flags)
  );

  // Stage 1 register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= ALU_OR;
    end else begin
      // When S1 can take a new request it either loads one or empties,
      // since its old content is moving into S2 on this same edge.
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
      end
      if (w_in_fire) begin
        r_s1_a  <= bus.operandA;
        r_s1_b  <= bus.operandB;
        r_s1_op <= bus.op;
      end
    end
  end

  // Stage 2 register; data is only overwritten by a real S1 entry so the
  // last result stays on the bus, and it is frozen while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_result <= w_core_result;
        r_s2_flags  <= w_core_flags;
      end
    end
  end

  // Delivered-result counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op_count <= '0;
    end else if (w_out_fire) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.result    = r_s2_result;
  assign bus.flags     = r_s2_flags;
  assign bus.op_count  = r_op_count;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Self-checking bench for alu_pipe (WIDTH=8, CNT_W=4).
//               Directed vector table with constant expectations, plus a
//               scoreboard fed from an independent reference model for every
//               accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int NVEC  = 12;

  logic clk;
  logic resetn;

  alu_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_pipe #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_count = 0;
  int delivered = 0;

  logic [WIDTH+3:0] sb_q[$];

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;   // {carry, overflow, negative, zero}
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model written from the arithmetic definitions (integer
  // arithmetic and signed range checks).
  function automatic logic [WIDTH+3:0] model(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
    int ua, ub, sa, sb, r, s;
    logic [WIDTH-1:0] res;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[WIDTH-1] ? ua - (1 << WIDTH) : ua;
    sb = b[WIDTH-1] ? ub - (1 << WIDTH) : ub;
    c = 1'b0;
    v = 1'b0;
    res = '0;
    case (op)
      3'd0: res = a | b;
      3'd1: res = a & b;
      3'd2: res = a ^ b;
      3'd3: res = '1;
      3'd4: begin
        r = ua + ub; res = r[WIDTH-1:0]; c = (r >= (1 << WIDTH));
        s = sa + sb; v = (s > (1 << (WIDTH-1)) - 1) || (s < -(1 << (WIDTH-1)));
      end
      3'd5: begin
        r = ua - ub; res = r[WIDTH-1:0]; c = (ua < ub);
        s = sa - sb; v = (s > (1 << (WIDTH-1)) - 1) || (s < -(1 << (WIDTH-1)));
      end
      3'd6: res = a << (ub % WIDTH);
      default: res = a >> (ub % WIDTH);
    endcase
    return {res, c, v, res[WIDTH-1], (res == '0)};
  endfunction

  // Scoreboard: sample between edges; a handshake seen here fires on the
  // next rising edge.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.operandA, bus.operandB, bus.op));
      if (bus.out_valid && bus.out_ready) begin
        logic [WIDTH+3:0] e;
        delivered++;
        exp_count = (exp_count + 1) % (1 << CNT_W);
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got result 0x%0h with no request pending", bus.result);
        end else begin
          e = sb_q.pop_front();
          if ({bus.result, bus.flags} !== e) begin
            n_fail++;
            $display("FAIL sb_result: got 0x%0h/%b expected 0x%0h/%b",
                     bus.result, bus.flags, e[WIDTH+3:4], e[3:0]);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    sb_q.delete();
    exp_count = 0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drive_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
    bus.in_valid = 1'b1;
    bus.operandA = a;
    bus.operandB = b;
    bus.op       = alu_op_e'(op);
  endtask

  // Back-to-back stream of n requests; out_ready low for cycles lo..hi.
  task automatic run_stream(input int n, input int lo, input int hi, input int exp_cnt);
    int sent = 0;
    int k;
    delivered = 0;
    for (k = 0; k < 200; k++) begin
      if (sent == n && sb_q.size() == 0) break;
      @(posedge clk); #1;
      bus.out_ready = !(k >= lo && k <= hi);
      if (sent < n) drive_req(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)));
      else bus.in_valid = 1'b0;
      @(negedge clk);
      if (k >= lo && k <= hi) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      end
      if (k == hi + 1) check("full_pass_in_ready", 32'(bus.in_ready), 32'd1);
      if (bus.in_valid && bus.in_ready) sent++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stream_sent", 32'(sent), 32'(n));
    check("stream_delivered", 32'(delivered), 32'(n));
    check("stream_op_count", 32'(bus.op_count), 32'(exp_cnt));
  endtask

  initial begin
    // Directed vectors: {op, A, B, result, flags}
    vecs[0]  = '{3'd4, 8'hF0, 8'h20, 8'h10, 4'b1000};
    vecs[1]  = '{3'd5, 8'h80, 8'h01, 8'h7F, 4'b0100};
    vecs[2]  = '{3'd5, 8'h05, 8'h05, 8'h00, 4'b0001};
    vecs[3]  = '{3'd6, 8'h81, 8'hF9, 8'h02, 4'b0000};
    vecs[4]  = '{3'd7, 8'h81, 8'h07, 8'h01, 4'b0000};
    vecs[5]  = '{3'd3, 8'h12, 8'h34, 8'hFF, 4'b0010};
    vecs[6]  = '{3'd0, 8'hA0, 8'h05, 8'hA5, 4'b0010};
    vecs[7]  = '{3'd1, 8'hF0, 8'h0F, 8'h00, 4'b0001};
    vecs[8]  = '{3'd2, 8'hFF, 8'h0F, 8'hF0, 4'b0010};
    vecs[9]  = '{3'd4, 8'h7F, 8'h01, 8'h80, 4'b0110};
    vecs[10] = '{3'd5, 8'h00, 8'h01, 8'hFF, 4'b1010};
    vecs[11] = '{3'd7, 8'h80, 8'h08, 8'h80, 4'b0010};

    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.operandA  = '0;
    bus.operandB  = '0;
    bus.op        = ALU_OR;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    resetn = 1'b1;

    // Directed vectors, one at a time, with latency check
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      drive_req(vecs[i].a, vecs[i].b, vecs[i].op);
      @(negedge clk);
      check("vec_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;             // accepting edge
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("vec_latency_early", 32'(bus.out_valid), 32'd0);
      @(negedge clk);                 // after the following edge
      check("vec_out_valid", 32'(bus.out_valid), 32'd1);
      check("vec_result", 32'(bus.result), 32'(vecs[i].res));
      check("vec_flags", 32'(bus.flags), 32'(vecs[i].flg));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("vec_op_count", 32'(bus.op_count), 32'(NVEC % (1 << CNT_W)));

    // Reset with two requests in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive_req(8'h11, 8'h22, 3'd4);
    @(posedge clk); #1;
    drive_req(8'h33, 8'h44, 3'd2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("inflight_out_valid", 32'(bus.out_valid), 32'd1);
    check("inflight_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    sb_q.delete();
    exp_count = 0;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_op_count", 32'(bus.op_count), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Stream of 10 with backpressure in cycles 3..6
    run_stream(10, 3, 6, 10);

    // Counter wrap: 17 deliveries with a 4-bit counter
    do_reset();
    run_stream(17, -1, -2, 1);

    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_pipe
`default_nettype wire
